// File: rtl/udp_pkg.sv
// Shared constants and state encoding for the UDP transmit framer.
// Packet geometry follows the receive-side parser layout.
package udp_pkg;

  localparam int unsigned PKT_BEATS   = 63;
  localparam int unsigned DATA_W      = 256;
  localparam int unsigned WORD_W      = 32;
  localparam int unsigned OP_W        = 16;
  localparam int unsigned OPCODE_LSB  = 160;
  localparam int unsigned FIRST_WORDS = 5;
  localparam int unsigned TAIL_LSB    = 128;
  localparam int unsigned CNT_W       = 6;

  localparam int unsigned CARRY_W   = (8 - FIRST_WORDS) * WORD_W;
  localparam int unsigned CARRY_LSB = FIRST_WORDS * WORD_W;
  localparam int unsigned BODY_LAST = PKT_BEATS - 3;

  localparam logic [DATA_W-1:0] HEADER = '0;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    FIRST,
    BODY,
    TAIL
  } tx_state_e;

endpackage

// File: rtl/udp_tx_gearbox.sv
// Carry buffer and lane mux that realigns payload words
// around the 5-word first beat.
module udp_tx_gearbox
  import udp_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  tx_state_e         state,
  input  logic              step,
  input  logic [OP_W-1:0]   op,
  input  logic [DATA_W-1:0] in_data,
  output logic [DATA_W-1:0] beat
);

  logic [CARRY_W-1:0] carry;

  always_comb begin
    beat = HEADER;
    unique case (state)
      FIRST: begin
        beat = '0;
        beat[OPCODE_LSB +: OP_W] = op;
        beat[CARRY_LSB-1:0] = in_data[CARRY_LSB-1:0];
      end
      BODY: beat = {in_data[CARRY_LSB-1:0], carry};
      TAIL: beat = {in_data[WORD_W-1:0], carry,
                    {TAIL_LSB{1'b0}}};
      default: beat = HEADER;
    endcase
  end

  // Upper lanes spill into the next output beat.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      carry <= '0;
    end else if (step && (state == FIRST || state == BODY)) begin
      carry <= in_data[DATA_W-1 -: CARRY_W];
    end
  end

endmodule

// File: rtl/udp_packet_tx.sv
// Transmit framer: one command plus 62 payload beats in,
// one 63-beat packet out with a registered output stage.
module udp_packet_tx
  import udp_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [OP_W-1:0]   Cmd_op,
  input  logic              Cmd_valid,
  output logic              Cmd_ready,
  input  logic [DATA_W-1:0] In_data,
  input  logic              In_valid,
  output logic              In_ready,
  output logic [DATA_W-1:0] Out_data,
  output logic              Out_valid,
  input  logic              Out_ready,
  output logic              Out_last
);

  tx_state_e          state;
  tx_state_e          state_nx;
  logic [OP_W-1:0]    op;
  logic [CNT_W-1:0]   count;
  logic [DATA_W-1:0]  beat;
  logic               adv;
  logic               take;
  logic               load;

  assign adv       = !Out_valid || Out_ready;
  assign Cmd_ready = (state == IDLE);
  assign In_ready  = (state == FIRST || state == BODY ||
                      state == TAIL) && adv;
  assign take      = In_valid && In_ready;
  assign load      = (state == HDR && adv) || take;

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (Cmd_valid) state_nx = HDR;
      HDR:   if (adv) state_nx = FIRST;
      FIRST: if (take) state_nx = BODY;
      BODY:  if (take && count == CNT_W'(BODY_LAST))
               state_nx = TAIL;
      TAIL:  if (take) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      op    <= '0;
      count <= '0;
    end else begin
      state <= state_nx;
      if (Cmd_valid && Cmd_ready) begin
        op    <= Cmd_op;
        count <= '0;
      end else if (take) begin
        count <= count + CNT_W'(1);
      end
    end
  end

  // Output holds until accepted; a missing input beat leaves a bubble.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      Out_data  <= '0;
      Out_valid <= 1'b0;
      Out_last  <= 1'b0;
    end else if (adv) begin
      if (load) begin
        Out_data  <= beat;
        Out_valid <= 1'b1;
        Out_last  <= (state == TAIL);
      end else begin
        Out_valid <= 1'b0;
        Out_last  <= 1'b0;
      end
    end
  end

  udp_tx_gearbox u_gearbox (
    .clk     (clk),
    .reset   (reset),
    .state   (state),
    .step    (load),
    .op      (op),
    .in_data (In_data),
    .beat    (beat)
  );

endmodule

// File: tb/tb_udp_packet_tx.sv
// Randomized bench for udp_packet_tx with a packet-level
// scoreboard built from the payload word layout.
module tb_udp_packet_tx;

  logic         clk = 1'b0;
  logic         reset;
  logic [15:0]  Cmd_op;
  logic         Cmd_valid;
  logic         Cmd_ready;
  logic [255:0] In_data;
  logic         In_valid;
  logic         In_ready;
  logic [255:0] Out_data;
  logic         Out_valid;
  logic         Out_ready;
  logic         Out_last;

  always #5 clk = ~clk;

  udp_packet_tx dut (
    .clk       (clk),
    .reset     (reset),
    .Cmd_op    (Cmd_op),
    .Cmd_valid (Cmd_valid),
    .Cmd_ready (Cmd_ready),
    .In_data   (In_data),
    .In_valid  (In_valid),
    .In_ready  (In_ready),
    .Out_data  (Out_data),
    .Out_valid (Out_valid),
    .Out_ready (Out_ready),
    .Out_last  (Out_last)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [255:0] in_q[$];
  logic [255:0] exp_q[$];
  bit           last_q[$];
  int           idx_q[$];
  logic [15:0]  cmd_q[$];
  int           hdr_cyc[$];

  bit           idx_mode;
  int           rdy_mode;
  int           gap_at;
  int           gap_left;
  int           cyc;
  int           in_cnt;
  int           bubbles;
  bit           pkt_on;
  bit           prev_stall;
  logic [255:0] prev_data;
  logic         prev_last;

  task automatic chk(input string tag, input logic [255:0] got,
                     input logic [255:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic void new_packet(input logic [15:0] op);
    logic [31:0]  p[489];
    logic [255:0] b;
    int           w;
    for (int i = 0; i < 489; i++)
      p[i] = idx_mode ? 32'(i) : $urandom;
    for (int j = 0; j < 62; j++) begin
      b = '0;
      for (int l = 0; l < 8; l++) begin
        w = 8 * j + l;
        b[32*l +: 32] = (w < 489) ? p[w] : $urandom;
      end
      in_q.push_back(b);
    end
    for (int k = 0; k < 63; k++) begin
      b = '0;
      if (k == 1) begin
        b[175:160] = op;
        for (int l = 0; l < 5; l++) b[32*l +: 32] = p[l];
      end else if (k >= 2 && k <= 61) begin
        for (int l = 0; l < 8; l++) b[32*l +: 32] = p[8*k-11+l];
      end else if (k == 62) begin
        for (int l = 4; l < 8; l++) b[32*l +: 32] = p[481+l];
      end
      exp_q.push_back(b);
      last_q.push_back(k == 62);
      idx_q.push_back(k);
    end
  endfunction

  task automatic cycle();
    bit out_hs;
    bit in_hs;
    bit cmd_hs;
    @(negedge clk);
    cyc++;
    case (rdy_mode)
      1:       Out_ready = cyc[0];
      2:       Out_ready = 1'($urandom_range(0, 1));
      default: Out_ready = 1'b1;
    endcase
    In_valid = (in_q.size() > 0) && (gap_left == 0);
    In_data  = In_valid ? in_q[0] : '0;
    if (gap_left > 0) gap_left--;
    Cmd_valid = cmd_q.size() > 0;
    if (Cmd_valid && Cmd_ready) Cmd_op = cmd_q[0];
    else if (Cmd_valid)         Cmd_op = 16'($urandom);
    else                        Cmd_op = '0;
    #1;
    if (Cmd_valid) chk("cmd_ready", 256'(Cmd_ready),
                       256'(in_q.size() == 0));
    if (prev_stall) begin
      chk("hold_valid", 256'(Out_valid), 256'(1));
      chk("hold_data", Out_data, prev_data);
      chk("hold_last", 256'(Out_last), 256'(prev_last));
    end
    if (Out_valid && !Out_ready)
      chk("stall_in_ready", 256'(In_ready), 256'(0));
    if (pkt_on && !Out_valid) bubbles++;
    out_hs = Out_valid && Out_ready;
    in_hs  = In_valid && In_ready;
    cmd_hs = Cmd_valid && Cmd_ready;
    if (out_hs) begin
      if (exp_q.size() == 0) begin
        chk("extra_beat", 256'(1), 256'(0));
      end else begin
        chk($sformatf("beat%0d", idx_q[0]), Out_data, exp_q[0]);
        chk($sformatf("last%0d", idx_q[0]), 256'(Out_last),
            256'(last_q[0]));
        if (idx_q[0] == 0) begin
          hdr_cyc.push_back(cyc);
          pkt_on = 1'b1;
        end
        if (idx_q[0] == 62) pkt_on = 1'b0;
        void'(exp_q.pop_front());
        void'(last_q.pop_front());
        void'(idx_q.pop_front());
      end
    end
    if (in_hs) begin
      void'(in_q.pop_front());
      in_cnt++;
      if (in_cnt == gap_at + 1) gap_left = 3;
    end
    if (cmd_hs) new_packet(cmd_q.pop_front());
    prev_stall = Out_valid && !Out_ready;
    prev_data  = Out_data;
    prev_last  = Out_last;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((exp_q.size() > 0 || cmd_q.size() > 0) && n < budget) begin
      cycle();
      n++;
    end
    chk("drain_in_budget", 256'(n < budget), 256'(1));
    repeat (2) cycle();
  endtask

  task automatic run_until_idx(input int idx, input int budget);
    int n = 0;
    while (!(Out_valid && idx_q.size() > 0 && idx_q[0] == idx)
           && n < budget) begin
      cycle();
      n++;
    end
    chk("reach_beat", 256'(n < budget), 256'(1));
  endtask

  function automatic void clear_tb();
    in_q.delete();
    exp_q.delete();
    last_q.delete();
    idx_q.delete();
    cmd_q.delete();
    hdr_cyc.delete();
    gap_left   = 0;
    pkt_on     = 1'b0;
    prev_stall = 1'b0;
  endfunction

  initial begin
    reset     = 1'b0;
    Cmd_op    = '0;
    Cmd_valid = 1'b0;
    In_data   = '0;
    In_valid  = 1'b0;
    Out_ready = 1'b1;
    idx_mode  = 1'b1;
    rdy_mode  = 0;
    gap_at    = -100;
    cyc       = 0;
    clear_tb();
    #12;
    chk("rst_cmd_ready", 256'(Cmd_ready), 256'(1));
    chk("rst_in_ready", 256'(In_ready), 256'(0));
    chk("rst_out_valid", 256'(Out_valid), 256'(0));
    chk("rst_out_last", 256'(Out_last), 256'(0));
    chk("rst_out_data", Out_data, 256'(0));
    @(negedge clk);
    reset = 1'b1;
    repeat (2) cycle();
    chk("idle_out_valid", 256'(Out_valid), 256'(0));

    // indexed payload, full rate
    in_cnt = 0;
    bubbles = 0;
    cmd_q.push_back(16'h0001);
    drain(200);
    chk("in_handshakes", 256'(in_cnt), 256'(62));
    chk("no_bubbles", 256'(bubbles), 256'(0));

    // output backpressure every other cycle
    idx_mode = 1'b0;
    rdy_mode = 1;
    in_cnt = 0;
    cmd_q.push_back(16'($urandom));
    drain(400);
    chk("stall_in_handshakes", 256'(in_cnt), 256'(62));

    // input gap after beat 10
    rdy_mode = 0;
    in_cnt = 0;
    bubbles = 0;
    gap_at = 10;
    cmd_q.push_back(16'($urandom));
    drain(200);
    chk("gap_bubbles", 256'(bubbles > 0), 256'(1));
    gap_at = -100;

    // back-to-back commands
    hdr_cyc.delete();
    cmd_q.push_back(16'h0001);
    cmd_q.push_back(16'h0002);
    drain(300);
    chk("hdr_count", 256'(hdr_cyc.size()), 256'(2));
    if (hdr_cyc.size() == 2)
      chk("hdr_period", 256'(hdr_cyc[1] - hdr_cyc[0]), 256'(64));

    // reset mid-packet
    cmd_q.push_back(16'h0BAD);
    run_until_idx(30, 200);
    chk("pre_rst_valid", 256'(Out_valid), 256'(1));
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_valid", 256'(Out_valid), 256'(0));
    chk("mid_rst_last", 256'(Out_last), 256'(0));
    chk("mid_rst_cmd_ready", 256'(Cmd_ready), 256'(1));
    chk("mid_rst_in_ready", 256'(In_ready), 256'(0));
    clear_tb();
    @(negedge clk);
    reset = 1'b1;
    cmd_q.push_back(16'($urandom));
    drain(200);

    // command arriving while busy
    cmd_q.push_back(16'h0003);
    run_until_idx(20, 200);
    cmd_q.push_back(16'h0004);
    cycle();
    chk("busy_cmd_ready", 256'(Cmd_ready), 256'(0));
    drain(300);

    // random backpressure and random gaps
    rdy_mode = 2;
    for (int t = 0; t < 3; t++) begin
      gap_at = int'($urandom_range(0, 60));
      cmd_q.push_back(16'($urandom));
      drain(600);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
